// File: rtl/tiny16_control.sv
// tiny16 instruction sequencer: fetch/decode/execute FSM driving register-file, ALU and memory strobes.
// Outputs are registered together with the state they belong to; a mem_ready seen at an edge shows up as the following cycle's pulse.
module tiny16_control #(
  parameter bit ILLEGAL_HALT = 1'b1,
  parameter int IMM_W        = 6
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [15:0] instr,
  input  logic        mem_ready,
  input  logic        zero_flag,
  output logic [2:0]  src_sel,
  output logic [2:0]  dst_sel,
  output logic        in_en,
  output logic        out_en,
  output logic        pc_inc,
  output logic [3:0]  alu_op,
  output logic        alu_en,
  output logic [15:0] imm,
  output logic        imm_en,
  output logic        mem_rd,
  output logic        mem_wr,
  output logic        halted,
  output logic        illegal
);

  localparam logic [3:0] OP_MOV   = 4'h1;
  localparam logic [3:0] OP_ADD   = 4'h2;
  localparam logic [3:0] OP_SUB   = 4'h3;
  localparam logic [3:0] OP_AND   = 4'h4;
  localparam logic [3:0] OP_OR    = 4'h5;
  localparam logic [3:0] OP_XOR   = 4'h6;
  localparam logic [3:0] OP_LOAD  = 4'h7;
  localparam logic [3:0] OP_STORE = 4'h8;
  localparam logic [3:0] OP_JZ    = 4'h9;
  localparam logic [3:0] OP_LDI   = 4'hA;
  localparam logic [3:0] OP_HALT  = 4'hF;

  typedef enum logic [3:0] {
    FETCH0, FETCH1, DECODE, EXEC, LOAD_W, LOAD_WB, MEMA, MEMW, STORE_WB, HALT
  } state_t;

  state_t      state;
  logic [15:0] ir;
  logic [3:0]  op;
  logic        undef_op;

  always_comb begin
    op       = ir[15:12];
    undef_op = (op >= 4'hB) && (op <= 4'hE);
  end

  // alu_op and imm are pure field decodes of the instruction register
  assign alu_op = op;
  assign imm    = {{(16-IMM_W){ir[IMM_W-1]}}, ir[IMM_W-1:0]};

  always_ff @(posedge clk) begin
    if (rst) begin
      state   <= FETCH0;
      ir      <= '0;
      src_sel <= '0;
      dst_sel <= '0;
      in_en   <= 1'b0;
      out_en  <= 1'b0;
      pc_inc  <= 1'b0;
      alu_en  <= 1'b0;
      imm_en  <= 1'b0;
      mem_rd  <= 1'b0;
      mem_wr  <= 1'b0;
      illegal <= 1'b0;
      halted  <= 1'b0;
    end else begin
      in_en   <= 1'b0;
      out_en  <= 1'b0;
      pc_inc  <= 1'b0;
      alu_en  <= 1'b0;
      imm_en  <= 1'b0;
      mem_rd  <= 1'b0;
      mem_wr  <= 1'b0;
      illegal <= 1'b0;
      case (state)
        FETCH0: begin
          state   <= FETCH1;
          src_sel <= 3'd0;
          out_en  <= 1'b1;
          mem_rd  <= 1'b1;
        end
        FETCH1: begin
          if (mem_ready) begin
            state   <= DECODE;
            ir      <= instr;
            src_sel <= instr[8:6];
            dst_sel <= instr[11:9];
            pc_inc  <= 1'b1;
          end else begin
            out_en <= 1'b1;
            mem_rd <= 1'b1;
          end
        end
        DECODE: begin
          case (op)
            OP_LOAD: begin
              state  <= LOAD_W;
              out_en <= 1'b1;
              mem_rd <= 1'b1;
            end
            OP_STORE: begin
              // address phase: put mem[dst]'s address (gpr[dst]) on the bus
              state   <= MEMA;
              src_sel <= ir[11:9];
              out_en  <= 1'b1;
            end
            default: begin
              state <= EXEC;
              case (op)
                OP_MOV: begin
                  out_en <= 1'b1;
                  in_en  <= 1'b1;
                end
                OP_ADD, OP_SUB, OP_AND, OP_OR, OP_XOR: begin
                  alu_en <= 1'b1;
                  in_en  <= 1'b1;
                end
                OP_LDI: begin
                  imm_en <= 1'b1;
                  in_en  <= 1'b1;
                end
                OP_JZ: begin
                  if (zero_flag) begin
                    dst_sel <= 3'd0;
                    out_en  <= 1'b1;
                    in_en   <= 1'b1;
                  end
                end
                default: illegal <= undef_op;
              endcase
            end
          endcase
        end
        EXEC: begin
          if (op == OP_HALT || (undef_op && ILLEGAL_HALT)) begin
            state  <= HALT;
            halted <= 1'b1;
          end else begin
            state   <= FETCH0;
            src_sel <= 3'd0;
            out_en  <= 1'b1;
          end
        end
        LOAD_W: begin
          if (mem_ready) begin
            state <= LOAD_WB;
            in_en <= 1'b1;
          end else begin
            out_en <= 1'b1;
            mem_rd <= 1'b1;
          end
        end
        LOAD_WB: begin
          state   <= FETCH0;
          src_sel <= 3'd0;
          out_en  <= 1'b1;
        end
        MEMA: begin
          state   <= MEMW;
          src_sel <= ir[8:6];
          out_en  <= 1'b1;
          mem_wr  <= 1'b1;
        end
        MEMW: begin
          if (mem_ready) begin
            state <= STORE_WB;
          end else begin
            out_en <= 1'b1;
            mem_wr <= 1'b1;
          end
        end
        STORE_WB: begin
          state   <= FETCH0;
          src_sel <= 3'd0;
          out_en  <= 1'b1;
        end
        HALT: state <= HALT;
        default: state <= FETCH0;
      endcase
    end
  end

endmodule

// File: tb/tb_tiny16_control.sv
// Bench for tiny16_control: per-instruction cycle traces generated from the instruction semantics,
// replayed with random wait states and random noise on don't-care inputs.
module tb_tiny16_control;
  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [15:0] instr = '0;
  logic        mem_ready = 1'b0;
  logic        zero_flag = 1'b0;

  typedef struct packed {
    logic [2:0]  src_sel;
    logic [2:0]  dst_sel;
    logic        in_en;
    logic        out_en;
    logic        pc_inc;
    logic        alu_en;
    logic        imm_en;
    logic        mem_rd;
    logic        mem_wr;
    logic        illegal;
    logic        halted;
    logic [3:0]  alu_op;
    logic [15:0] imm;
  } obs_t;

  typedef struct packed {
    logic        rdy;
    logic        zf;
    logic [15:0] word;
  } stim_t;

  obs_t obs [2];

  // g_dut[0] halts on undefined opcodes, g_dut[1] treats them as NOP
  for (genvar g = 0; g < 2; g++) begin : g_dut
    logic [2:0]  src_sel, dst_sel;
    logic        in_en, out_en, pc_inc, alu_en, imm_en, mem_rd, mem_wr, halted, illegal;
    logic [3:0]  alu_op;
    logic [15:0] imm;
    tiny16_control #(.ILLEGAL_HALT(g == 0), .IMM_W(6)) dut (
      .clk(clk), .rst(rst), .instr(instr), .mem_ready(mem_ready), .zero_flag(zero_flag),
      .src_sel(src_sel), .dst_sel(dst_sel), .in_en(in_en), .out_en(out_en), .pc_inc(pc_inc),
      .alu_op(alu_op), .alu_en(alu_en), .imm(imm), .imm_en(imm_en), .mem_rd(mem_rd),
      .mem_wr(mem_wr), .halted(halted), .illegal(illegal)
    );
    assign obs[g] = {src_sel, dst_sel, in_en, out_en, pc_inc, alu_en, imm_en,
                     mem_rd, mem_wr, illegal, halted, alu_op, imm};
  end

  always #5 clk = ~clk;

  int     tests = 0;
  int     failed = 0;
  obs_t   exp_q[$];
  obs_t   act_q[$];
  stim_t  stim_q[$];

  // architectural view the reference model keeps between instructions
  logic [2:0]  m_src = '0;
  logic [2:0]  m_dst = '0;
  logic [3:0]  m_alu = '0;
  logic [15:0] m_imm = '0;
  bit          m_fresh = 1'b1;

  function automatic logic rnd1();
    return 1'($urandom_range(0, 1));
  endfunction

  function automatic logic [15:0] rnd16();
    return 16'($urandom());
  endfunction

  function automatic obs_t cur();
    obs_t e;
    e = '0;
    e.src_sel = m_src;
    e.dst_sel = m_dst;
    e.alu_op  = m_alu;
    e.imm     = m_imm;
    return e;
  endfunction

  function automatic void push(obs_t e, logic rdy, logic zf, logic [15:0] w);
    stim_t s;
    s.rdy = rdy;
    s.zf = zf;
    s.word = w;
    exp_q.push_back(e);
    stim_q.push_back(s);
  endfunction

  // Expected cycles of one instruction: fw / mw = cycles memory keeps mem_ready low.
  function automatic void model_instr(logic [15:0] w, int fw, int mw, logic zf, bit hmode, int hcyc);
    obs_t e;
    logic [3:0] op;
    bit undef;
    op = w[15:12];
    undef = (op >= 4'hB) && (op <= 4'hE);
    m_src = 3'd0;
    e = cur();
    e.out_en = !m_fresh;
    m_fresh = 1'b0;
    push(e, rnd1(), zf, rnd16());
    for (int k = 0; k <= fw; k++) begin
      e = cur();
      e.out_en = 1'b1;
      e.mem_rd = 1'b1;
      push(e, logic'(k == fw), zf, (k == fw) ? w : rnd16());
    end
    m_src = w[8:6];
    m_dst = w[11:9];
    m_alu = op;
    m_imm = {{10{w[5]}}, w[5:0]};
    e = cur();
    e.pc_inc = 1'b1;
    push(e, rnd1(), zf, rnd16());
    if (op == 4'h7) begin
      for (int k = 0; k <= mw; k++) begin
        e = cur();
        e.out_en = 1'b1;
        e.mem_rd = 1'b1;
        push(e, logic'(k == mw), zf, rnd16());
      end
      e = cur();
      e.in_en = 1'b1;
      push(e, rnd1(), zf, rnd16());
    end else if (op == 4'h8) begin
      m_src = w[11:9];
      e = cur();
      e.out_en = 1'b1;
      push(e, rnd1(), zf, rnd16());
      m_src = w[8:6];
      for (int k = 0; k <= mw; k++) begin
        e = cur();
        e.out_en = 1'b1;
        e.mem_wr = 1'b1;
        push(e, logic'(k == mw), zf, rnd16());
      end
      push(cur(), rnd1(), zf, rnd16());
    end else begin
      e = cur();
      if (op == 4'h1) begin
        e.out_en = 1'b1;
        e.in_en = 1'b1;
      end else if (op >= 4'h2 && op <= 4'h6) begin
        e.alu_en = 1'b1;
        e.in_en = 1'b1;
      end else if (op == 4'hA) begin
        e.imm_en = 1'b1;
        e.in_en = 1'b1;
      end else if (op == 4'h9 && zf) begin
        m_dst = 3'd0;
        e.dst_sel = 3'd0;
        e.out_en = 1'b1;
        e.in_en = 1'b1;
      end else if (undef) begin
        e.illegal = 1'b1;
      end
      push(e, rnd1(), zf, rnd16());
      if (op == 4'hF || (undef && hmode)) begin
        for (int k = 0; k < hcyc; k++) begin
          e = cur();
          e.halted = 1'b1;
          push(e, rnd1(), rnd1(), rnd16());
        end
      end
    end
  endfunction

  task automatic clear_q();
    exp_q.delete();
    stim_q.delete();
    act_q.delete();
  endtask

  // Replays stim_q (or its first n entries) and records one output sample per cycle.
  task automatic play(input int which, input int n);
    act_q.delete();
    foreach (stim_q[i]) begin
      if (n < 0 || i < n) begin
        act_q.push_back(obs[which]);
        mem_ready = stim_q[i].rdy;
        zero_flag = stim_q[i].zf;
        instr     = stim_q[i].word;
        @(posedge clk);
        #1;
      end
    end
  endtask

  function automatic int first_diff();
    if (act_q.size() != exp_q.size()) return 0;
    foreach (exp_q[i]) if (act_q[i] !== exp_q[i]) return i;
    return -1;
  endfunction

  task automatic do_reset();
    rst = 1'b1;
    @(posedge clk);
    #1;
    rst = 1'b0;
    m_src = '0;
    m_dst = '0;
    m_alu = '0;
    m_imm = '0;
    m_fresh = 1'b1;
  endtask

  task automatic test_reset();
    int d, n;
    mem_ready = 1'b1;
    zero_flag = 1'b1;
    instr = 16'hFFFF;
    do_reset();
    tests++;
    if (obs[0] !== '0) begin
      failed++;
      $display("FAIL reset_outputs: got %h want 0", obs[0]);
    end
    tests++;
    if (obs[1] !== '0) begin
      failed++;
      $display("FAIL reset_outputs_nohalt: got %h want 0", obs[1]);
    end
    clear_q();
    model_instr(16'h0000, 0, 0, 1'b0, 1'b1, 0);
    play(0, -1);
    d = first_diff();
    tests++;
    if (d !== -1) begin
      failed++;
      $display("FAIL reset_fetch_trace: cycle %0d got %h want %h", d, act_q[d], exp_q[d]);
    end
    tests++;
    if (act_q[1].out_en !== 1'b1 || act_q[1].src_sel !== 3'd0) begin
      failed++;
      $display("FAIL reset_fetch1: got out_en=%b src=%0d want out_en=1 src=0", act_q[1].out_en, act_q[1].src_sel);
    end
    n = 0;
    foreach (act_q[i]) n += int'(act_q[i].pc_inc);
    tests++;
    if (n !== 1) begin
      failed++;
      $display("FAIL reset_pc_inc_count: got %0d want 1", n);
    end
  endtask

  task automatic test_add();
    int d;
    clear_q();
    model_instr(16'h2250, 0, 0, 1'b0, 1'b1, 0);
    play(0, -1);
    d = first_diff();
    tests++;
    if (d !== -1) begin
      failed++;
      $display("FAIL add_trace: cycle %0d got %h want %h", d, act_q[d], exp_q[d]);
    end
    tests++;
    if (act_q[3].alu_op !== 4'd2 || act_q[3].alu_en !== 1'b1 || act_q[3].in_en !== 1'b1 || act_q[3].out_en !== 1'b0) begin
      failed++;
      $display("FAIL add_exec: got %h want alu_op=2 alu_en=1 in_en=1 out_en=0", act_q[3]);
    end
    tests++;
    if (obs[0].out_en !== 1'b1 || obs[0].src_sel !== 3'd0 || obs[0].mem_rd !== 1'b0) begin
      failed++;
      $display("FAIL add_back_to_fetch0: got %h want out_en=1 src=0 mem_rd=0", obs[0]);
    end
  endtask

  task automatic test_load();
    int d, n_in, n_rd;
    clear_q();
    model_instr(16'h7480, 1, 3, 1'b0, 1'b1, 0);
    play(0, -1);
    d = first_diff();
    tests++;
    if (d !== -1) begin
      failed++;
      $display("FAIL load_trace: cycle %0d got %h want %h", d, act_q[d], exp_q[d]);
    end
    n_in = 0;
    n_rd = 0;
    foreach (act_q[i]) begin
      n_in += int'(act_q[i].in_en);
      n_rd += int'(act_q[i].mem_rd);
    end
    tests++;
    if (n_in !== 1 || n_rd !== 6) begin
      failed++;
      $display("FAIL load_counts: got in_en=%0d mem_rd=%0d want 1 and 6", n_in, n_rd);
    end
  endtask

  task automatic test_store();
    int d, n_in, n_wr;
    clear_q();
    model_instr(16'h8640, 0, 2, 1'b0, 1'b1, 0);
    play(0, -1);
    d = first_diff();
    tests++;
    if (d !== -1) begin
      failed++;
      $display("FAIL store_trace: cycle %0d got %h want %h", d, act_q[d], exp_q[d]);
    end
    n_in = 0;
    n_wr = 0;
    foreach (act_q[i]) begin
      n_in += int'(act_q[i].in_en);
      n_wr += int'(act_q[i].mem_wr);
    end
    tests++;
    if (n_in !== 0 || n_wr !== 3 || act_q[3].src_sel !== 3'd3) begin
      failed++;
      $display("FAIL store_phases: got in_en=%0d mem_wr=%0d addr_src=%0d want 0, 3, 3", n_in, n_wr, act_q[3].src_sel);
    end
  endtask

  task automatic test_jz();
    int d, n;
    clear_q();
    model_instr(16'h9100, 0, 0, 1'b0, 1'b1, 0);
    play(0, -1);
    d = first_diff();
    n = 0;
    foreach (act_q[i]) n += int'(act_q[i].in_en);
    tests++;
    if (d !== -1 || n !== 0) begin
      failed++;
      $display("FAIL jz_not_taken: first bad cycle %0d, in_en count %0d, want none and 0", d, n);
    end
    clear_q();
    model_instr(16'h9100, 0, 0, 1'b1, 1'b1, 0);
    play(0, -1);
    d = first_diff();
    tests++;
    if (d !== -1) begin
      failed++;
      $display("FAIL jz_taken_trace: cycle %0d got %h want %h", d, act_q[d], exp_q[d]);
    end
    tests++;
    if (act_q[3].dst_sel !== 3'd0 || act_q[3].in_en !== 1'b1 || act_q[3].out_en !== 1'b1) begin
      failed++;
      $display("FAIL jz_taken_exec: got %h want dst=0 in_en=1 out_en=1", act_q[3]);
    end
  endtask

  task automatic test_reset_mid_load();
    clear_q();
    model_instr(16'h7480, 0, 10, 1'b0, 1'b1, 0);
    play(0, 5);
    tests++;
    if (obs[0].mem_rd !== 1'b1) begin
      failed++;
      $display("FAIL midload_mem_rd: got %b want 1", obs[0].mem_rd);
    end
    mem_ready = 1'b1;
    do_reset();
    tests++;
    if (obs[0] !== '0) begin
      failed++;
      $display("FAIL midload_reset: got %h want 0", obs[0]);
    end
  endtask

  task automatic test_illegal();
    int d, n;
    do_reset();
    clear_q();
    model_instr(16'hB000, 0, 0, 1'b0, 1'b1, 8);
    play(0, -1);
    d = first_diff();
    tests++;
    if (d !== -1) begin
      failed++;
      $display("FAIL illegal_halt_trace: cycle %0d got %h want %h", d, act_q[d], exp_q[d]);
    end
    n = 0;
    foreach (act_q[i]) n += int'(act_q[i].illegal);
    tests++;
    if (n !== 1 || obs[0].halted !== 1'b1) begin
      failed++;
      $display("FAIL illegal_pulse: got pulses=%0d halted=%b want 1 and 1", n, obs[0].halted);
    end
    do_reset();
    tests++;
    if (obs[0] !== '0) begin
      failed++;
      $display("FAIL halt_reset: got %h want 0", obs[0]);
    end
    do_reset();
    clear_q();
    model_instr(16'hC123, 0, 0, 1'b0, 1'b0, 0);
    model_instr(16'hA3FB, 1, 0, 1'b0, 1'b0, 0);
    play(1, -1);
    d = first_diff();
    tests++;
    if (d !== -1) begin
      failed++;
      $display("FAIL illegal_nohalt_trace: cycle %0d got %h want %h", d, act_q[d], exp_q[d]);
    end
    n = 0;
    foreach (act_q[i]) n += int'(act_q[i].halted);
    tests++;
    if (n !== 0) begin
      failed++;
      $display("FAIL illegal_nohalt_halted: got %0d halted cycles want 0", n);
    end
  endtask

  task automatic test_back_to_back();
    int d, n;
    logic [3:0] op;
    do_reset();
    clear_q();
    for (int k = 0; k < 30; k++) begin
      op = 4'($urandom_range(0, 10));
      model_instr({op, 12'($urandom())}, $urandom_range(0, 2), $urandom_range(0, 3), rnd1(), 1'b1, 0);
    end
    model_instr(16'hF000, 0, 0, 1'b0, 1'b1, 4);
    play(0, -1);
    d = first_diff();
    tests++;
    if (d !== -1) begin
      failed++;
      $display("FAIL random_trace: cycle %0d got %h want %h", d, act_q[d], exp_q[d]);
    end
    n = 0;
    foreach (act_q[i])
      if ((act_q[i].in_en && act_q[i].pc_inc) ||
          (int'(act_q[i].out_en) + int'(act_q[i].alu_en) + int'(act_q[i].imm_en) > 1)) n++;
    tests++;
    if (n !== 0) begin
      failed++;
      $display("FAIL random_exclusion: got %0d violating cycles want 0", n);
    end
  endtask

  initial begin
    test_reset();
    test_add();
    test_load();
    test_store();
    test_jz();
    test_reset_mid_load();
    test_illegal();
    test_back_to_back();
    $display("[TB] %0d tests run, %0d failed", tests, failed);
    $finish;
  end

endmodule
